// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment capture path: segment patterns,
// FSM state encoding and digit-select helpers.
package seg_pkg;

  // Active-low segment patterns, seg[6:0] = g..a.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } seg_state_e;

  // True when exactly one digit enable is driven low.
  function automatic logic onehot_low(input logic [7:0] an);
    int unsigned zeros;
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  // Position of the lowest low bit; only meaningful when onehot_low() holds.
  function automatic logic [2:0] digit_idx(input logic [7:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_encode.sv
// Combinational seven-segment pattern to hex nibble lookup.
module seg_encode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       illegal_o
);

  always_comb begin
    nibble_o  = 4'h0;
    blank_o   = 1'b0;
    illegal_o = 1'b0;
    case (seg_i)
      SEG_0:     nibble_o = 4'h0;
      SEG_1:     nibble_o = 4'h1;
      SEG_2:     nibble_o = 4'h2;
      SEG_3:     nibble_o = 4'h3;
      SEG_4:     nibble_o = 4'h4;
      SEG_5:     nibble_o = 4'h5;
      SEG_6:     nibble_o = 4'h6;
      SEG_7:     nibble_o = 4'h7;
      SEG_8:     nibble_o = 4'h8;
      SEG_9:     nibble_o = 4'h9;
      SEG_A:     nibble_o = 4'hA;
      SEG_B:     nibble_o = 4'hB;
      SEG_C:     nibble_o = 4'hC;
      SEG_D:     nibble_o = 4'hD;
      SEG_E:     nibble_o = 4'hE;
      SEG_F:     nibble_o = 4'hF;
      SEG_BLANK: blank_o  = 1'b1;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Snoops a multiplexed 8-digit seven-segment display and reconstructs the
// shown hex value, committing a frame once every digit has been sampled.
module seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  seg,
  output logic [31:0] value,
  output logic [7:0]  dp,
  output logic [7:0]  blank,
  output logic        valid,
  output logic        err,
  output logic        frame_done
);

  logic [7:0]  an_q, seg_q, an_p_q, seg_p_q;
  seg_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  seen_q, seen_d;
  logic [31:0] sh_nib_q, sh_nib_d;
  logic [7:0]  sh_dp_q, sh_dp_d;
  logic [7:0]  sh_blank_q, sh_blank_d;
  logic [7:0]  sh_ill_q, sh_ill_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  dp_q, dp_d;
  logic [7:0]  blank_q, blank_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        frame_done_q, frame_done_d;

  logic [3:0]  enc_nib;
  logic        enc_blank, enc_ill;
  logic        an_changed, any_changed, is_onehot, sample, commit;
  logic [2:0]  idx;
  logic [3:0]  cnt_inc;

  seg_encode u_encode (
    .seg_i     (seg_q[6:0]),
    .nibble_o  (enc_nib),
    .blank_o   (enc_blank),
    .illegal_o (enc_ill)
  );

  assign an_changed  = (an_q != an_p_q);
  assign any_changed = an_changed || (seg_q != seg_p_q);
  assign is_onehot   = onehot_low(an_q);
  assign idx         = digit_idx(an_q);
  assign cnt_inc     = cnt_q + 4'd1;
  assign commit      = (seen_q == 8'hFF);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    case (state_q)
      StIdle: begin
        if (is_onehot) begin
          state_d = StSettle;
          cnt_d   = 4'd0;
        end
      end
      StSettle: begin
        if (any_changed) begin
          cnt_d   = 4'd0;
          state_d = is_onehot ? StSettle : StIdle;
        end else if (cnt_inc == 4'(SETTLE)) begin
          sample  = 1'b1;
          cnt_d   = 4'd0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHold: begin
        // Segment changes are ignored until the digit select moves on.
        if (an_changed) begin
          cnt_d   = 4'd0;
          state_d = is_onehot ? StSettle : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    seen_d     = commit ? 8'h00 : seen_q;
    sh_ill_d   = commit ? 8'h00 : sh_ill_q;
    sh_nib_d   = sh_nib_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    if (sample) begin
      sh_nib_d[{idx, 2'b00} +: 4] = enc_nib;
      sh_dp_d[idx]                = ~seg_q[7];
      sh_blank_d[idx]             = enc_blank;
      sh_ill_d[idx]               = enc_ill;
      seen_d[idx]                 = 1'b1;
    end
  end

  always_comb begin
    value_d      = value_q;
    dp_d         = dp_q;
    blank_d      = blank_q;
    valid_d      = valid_q;
    err_d        = err_q;
    frame_done_d = commit;
    if (commit) begin
      value_d = sh_nib_q;
      dp_d    = sh_dp_q;
      blank_d = sh_blank_q;
      valid_d = ~|sh_ill_q;
      err_d   = |sh_ill_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q         <= 8'hFF;
      seg_q        <= 8'hFF;
      an_p_q       <= 8'hFF;
      seg_p_q      <= 8'hFF;
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      seen_q       <= 8'h00;
      sh_nib_q     <= 32'h0;
      sh_dp_q      <= 8'h00;
      sh_blank_q   <= 8'h00;
      sh_ill_q     <= 8'h00;
      value_q      <= 32'h0;
      dp_q         <= 8'h00;
      blank_q      <= 8'h00;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an;
      seg_q        <= seg;
      an_p_q       <= an_q;
      seg_p_q      <= seg_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      sh_nib_q     <= sh_nib_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      sh_ill_q     <= sh_ill_d;
      value_q      <= value_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign value      = value_q;
  assign dp         = dp_q;
  assign blank      = blank_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign frame_done = frame_done_q;

endmodule
